// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory test sequencer: FSM state encoding,
// the data pattern constant and the pattern function.
package mem_test_pkg;

    localparam logic [31:0] PATTERN_XOR = 32'hA5A5_5A5A;

    typedef enum logic [2:0] {
        IDLE,
        WR_STROBE,
        WR_WAIT,
        RD_SETTLE,
        RD_WAIT,
        DONE
    } state_t;

    // Data written to (and expected back from) byte address a.
    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ PATTERN_XOR;
    endfunction

endpackage

// File: rtl/mem_test_watchdog.sv
// Per-access timeout counter for the memory test sequencer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       clear the counter (asserted outside the wait states)
//   i_count      count one cycle spent waiting for the cache
//   o_first_c    counter is at zero (first cycle of a wait)
//   o_expire_c   this waiting cycle is the TIMEOUT_CYCLES-th one
module mem_test_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_count,
    output logic o_first_c,
    output logic o_expire_c
);

    localparam int unsigned     CNT_W = 16;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counts waiting cycles; holds at the limit so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_first_c  = (r_cnt == '0);
    assign o_expire_c = i_count && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_test_sequencer.sv
// Built-in memory test sequencer: writes pattern(addr) to WORD_COUNT words
// starting at BASE_ADDR, reads them back and reports mismatches/timeouts.
// Optional build macro MEM_TEST_SEQUENCER_HALT_ON_ERROR_EN stops the run at
// the first mismatch or timeout.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      run request (accepted in IDLE or DONE)
//   address/data_in/write_enable  cache request
//   data_out/data_out_valid    cache response
//   busy/done/pass/timeout     run status
//   err_count/err_addr         mismatch count (saturating), first bad address
module mem_test_sequencer
    import mem_test_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned WORD_COUNT     = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] address,
    output logic [31:0] data_in,
    output logic [3:0]  write_enable,
    input  logic [31:0] data_out,
    input  logic        data_out_valid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] err_addr
);

    localparam int unsigned      IDX_W    = 16;
    localparam int unsigned      ERR_W    = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);
`ifdef MEM_TEST_SEQUENCER_HALT_ON_ERROR_EN
    localparam logic HALT_ON_ERROR = 1'b1;
`else
    localparam logic HALT_ON_ERROR = 1'b0;
`endif

    state_t           r_state,     w_state_nxt;
    logic [IDX_W-1:0] r_idx,       w_idx_nxt;
    logic [31:0]      r_address,   w_address_nxt;
    logic [31:0]      r_data_in,   w_data_in_nxt;
    logic [3:0]       r_we,        w_we_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_pass,      w_pass_nxt;
    logic             r_timeout,   w_timeout_nxt;
    logic [ERR_W-1:0] r_err_count, w_err_count_nxt;
    logic [31:0]      r_err_addr,  w_err_addr_nxt;

    logic        w_in_wait;
    logic        w_wd_first;
    logic        w_wd_expire;
    logic        w_accept;
    logic        w_fail;
    logic        w_step;
    logic [31:0] w_next_addr;

    assign w_in_wait   = (r_state == WR_WAIT) || (r_state == RD_WAIT);
    assign w_next_addr = r_address + 32'd4;

    mem_test_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (!w_in_wait),
        .i_count    (w_in_wait),
        .o_first_c  (w_wd_first),
        .o_expire_c (w_wd_expire)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_address   <= '0;
            r_data_in   <= '0;
            r_we        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_address   <= w_address_nxt;
            r_data_in   <= w_data_in_nxt;
            r_we        <= w_we_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_timeout   <= w_timeout_nxt;
            r_err_count <= w_err_count_nxt;
            r_err_addr  <= w_err_addr_nxt;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_address_nxt   = r_address;
        w_data_in_nxt   = r_data_in;
        w_timeout_nxt   = r_timeout;
        w_err_count_nxt = r_err_count;
        w_err_addr_nxt  = r_err_addr;
        w_accept        = 1'b0;
        w_fail          = 1'b0;
        w_step          = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt     = WR_STROBE;
                    w_idx_nxt       = '0;
                    w_address_nxt   = BASE_ADDR;
                    w_data_in_nxt   = pattern(BASE_ADDR);
                    w_timeout_nxt   = 1'b0;
                    w_err_count_nxt = '0;
                    w_err_addr_nxt  = '0;
                end
            end
            WR_STROBE: w_state_nxt = WR_WAIT;
            WR_WAIT: begin
                // Valid on the strobe-following cycle still belongs to the old access.
                w_accept = data_out_valid && !w_wd_first;
                w_step   = w_accept || w_wd_expire;
                w_fail   = !w_accept && w_wd_expire;
            end
            RD_SETTLE: w_state_nxt = RD_WAIT;
            RD_WAIT: begin
                w_accept = data_out_valid;
                w_step   = w_accept || w_wd_expire;
                w_fail   = w_accept ? (data_out != pattern(r_address)) : w_wd_expire;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_step && !w_accept) begin
            w_timeout_nxt = 1'b1;
        end

        if (w_fail) begin
            if (r_err_count != '1) begin
                w_err_count_nxt = r_err_count + ERR_W'(1);
            end
            if (r_err_count == '0) begin
                w_err_addr_nxt = r_address;
            end
        end

        // Move to the next word, the read phase, or the end of the run.
        if (w_step) begin
            if (HALT_ON_ERROR && w_fail) begin
                w_state_nxt = DONE;
            end else if (r_idx != LAST_IDX) begin
                w_idx_nxt     = r_idx + IDX_W'(1);
                w_address_nxt = w_next_addr;
                if (r_state == WR_WAIT) begin
                    w_data_in_nxt = pattern(w_next_addr);
                    w_state_nxt   = WR_STROBE;
                end else begin
                    w_state_nxt   = RD_SETTLE;
                end
            end else if (r_state == WR_WAIT) begin
                w_idx_nxt     = '0;
                w_address_nxt = BASE_ADDR;
                w_state_nxt   = RD_SETTLE;
            end else begin
                w_state_nxt = DONE;
            end
        end

        w_we_nxt   = (w_state_nxt == WR_STROBE) ? 4'b1111 : 4'b0000;
        w_busy_nxt = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done_nxt = (w_state_nxt == DONE);
        w_pass_nxt = w_done_nxt && (w_err_count_nxt == '0) && !w_timeout_nxt;
    end

    assign address      = r_address;
    assign data_in      = r_data_in;
    assign write_enable = r_we;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign timeout      = r_timeout;
    assign err_count    = r_err_count;
    assign err_addr     = r_err_addr;

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Testbench for mem_test_sequencer: two instances (base 0 and a wrapping base)
// driven by a behavioural cache model with configurable miss latency and
// corrupted words; results checked against a run-level reference model.
module tb_mem_test_sequencer;

    localparam int unsigned WC     = 4;
    localparam int unsigned TO_A   = 16;
    localparam int unsigned TO_B   = 5;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFF8;
    localparam logic [31:0] PAT    = 32'hA5A5_5A5A;
`ifdef MEM_TEST_SEQUENCER_HALT_ON_ERROR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start    [2];
    logic [31:0] address  [2];
    logic [31:0] data_in  [2];
    logic [3:0]  we       [2];
    logic [31:0] data_out [2];
    logic        valid    [2];
    logic        busy     [2];
    logic        done_o   [2];
    logic        pass_o   [2];
    logic        tmo      [2];
    logic [15:0] err_cnt  [2];
    logic [31:0] err_addr [2];

    // Cache model configuration (set by the stimulus).
    int          delay     [2] = '{default: 0};
    bit          valid_off [2] = '{default: 1'b0};
    logic [3:0]  corrupt   [2] = '{default: 4'h0};

    // Cache model and monitor state.
    logic [31:0] mem        [2][4];
    int          cnt        [2] = '{default: 0};
    logic [31:0] last_addr  [2] = '{default: 32'h0};
    logic [3:0]  prev_we    [2] = '{default: 4'h0};
    int          wr_n       [2] = '{default: 0};
    int          rd_n       [2] = '{default: 0};
    int          run_wr     [2] = '{default: 0};
    int          strobe_bad [2] = '{default: 0};
    int          busy_cyc   [2] = '{default: 0};
    bit          rd_phase   [2] = '{default: 1'b0};
    logic [31:0] last_wr    [2] = '{default: 32'h0};
    logic [31:0] last_rd    [2] = '{default: 32'h0};
    logic [31:0] wr_addr_log[2][256];
    logic [31:0] wr_data_log[2][256];
    logic [31:0] rd_log     [2][256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_test_sequencer #(.BASE_ADDR(BASE_A), .WORD_COUNT(WC), .TIMEOUT_CYCLES(TO_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .address(address[0]), .data_in(data_in[0]),
        .write_enable(we[0]), .data_out(data_out[0]), .data_out_valid(valid[0]), .busy(busy[0]),
        .done(done_o[0]), .pass(pass_o[0]), .timeout(tmo[0]), .err_count(err_cnt[0]), .err_addr(err_addr[0])
    );

    mem_test_sequencer #(.BASE_ADDR(BASE_B), .WORD_COUNT(WC), .TIMEOUT_CYCLES(TO_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .address(address[1]), .data_in(data_in[1]),
        .write_enable(we[1]), .data_out(data_out[1]), .data_out_valid(valid[1]), .busy(busy[1]),
        .done(done_o[1]), .pass(pass_o[1]), .timeout(tmo[1]), .err_count(err_cnt[1]), .err_addr(err_addr[1])
    );

    // Cache response: valid after 'delay' cycles on an unchanged address.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            valid[k]    = !valid_off[k] && (cnt[k] >= delay[k]);
            data_out[k] = mem[k][address[k][3:2]] ^ {31'd0, corrupt[k][address[k][3:2]]};
        end
    end

    // Memory storage plus logging of strobes, read addresses and run length.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            prev_we[k]   <= we[k];
            last_addr[k] <= address[k];
            if (we[k] != 4'h0 || address[k] != last_addr[k]) cnt[k] <= 0;
            else if (cnt[k] < 1000) cnt[k] <= cnt[k] + 1;
            if (busy[k]) begin
                busy_cyc[k] <= busy_cyc[k] + 1;
            end else begin
                run_wr[k]   <= 0;
                rd_phase[k] <= 1'b0;
            end
            if (we[k] != 4'h0) begin
                mem[k][address[k][3:2]]        <= data_in[k];
                wr_addr_log[k][wr_n[k][7:0]]   <= address[k];
                wr_data_log[k][wr_n[k][7:0]]   <= data_in[k];
                wr_n[k]                        <= wr_n[k] + 1;
                run_wr[k]                      <= run_wr[k] + 1;
                last_wr[k]                     <= address[k];
                if (prev_we[k] != 4'h0 || we[k] != 4'hF) strobe_bad[k] <= strobe_bad[k] + 1;
            end else if (busy[k] && run_wr[k] == int'(WC) &&
                         address[k] != (rd_phase[k] ? last_rd[k] : last_wr[k])) begin
                rd_phase[k]                  <= 1'b1;
                rd_log[k][rd_n[k][7:0]]      <= address[k];
                rd_n[k]                      <= rd_n[k] + 1;
                last_rd[k]                   <= address[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("rst_address%0d", k),  address[k], 32'h0);
        chk($sformatf("rst_data_in%0d", k),  data_in[k], 32'h0);
        chk($sformatf("rst_we%0d", k),       32'(we[k]), 32'h0);
        chk($sformatf("rst_busy%0d", k),     32'(busy[k]), 32'h0);
        chk($sformatf("rst_done%0d", k),     32'(done_o[k]), 32'h0);
        chk($sformatf("rst_pass%0d", k),     32'(pass_o[k]), 32'h0);
        chk($sformatf("rst_timeout%0d", k),  32'(tmo[k]), 32'h0);
        chk($sformatf("rst_err_cnt%0d", k),  32'(err_cnt[k]), 32'h0);
        chk($sformatf("rst_err_addr%0d", k), err_addr[k], 32'h0);
    endtask

    // One complete run on instance k, checked against the reference model.
    task automatic do_run(input int k, input int d, input bit voff, input logic [3:0] mask, input bit restart);
        logic [31:0] base;
        int to, s_wr, s_rd, s_bad, s_busy;
        int exp_wr, exp_rd, exp_err, exp_len, wlen, rlen;
        logic [31:0] exp_ea;
        bit exp_to, exp_pass;
        base = (k == 0) ? BASE_A : BASE_B;
        to   = (k == 0) ? int'(TO_A) : int'(TO_B);
        @(negedge clk);
        delay[k] = d; valid_off[k] = voff; corrupt[k] = mask;
        s_wr = wr_n[k]; s_rd = rd_n[k]; s_bad = strobe_bad[k]; s_busy = busy_cyc[k];
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        if (restart) begin
            repeat (4) @(negedge clk);
            start[k] = 1'b1;
            @(negedge clk);
            start[k] = 1'b0;
        end
        for (int c = 0; c < 3000 && !done_o[k]; c++) @(negedge clk);
        chk("done_reached", 32'(done_o[k]), 32'h1);

        // Reference model: outcome of the run from the access rules.
        exp_wr = int'(WC); exp_err = 0; exp_ea = 32'h0; exp_to = 1'b0; exp_rd = 0;
        if (voff) begin
            exp_to = 1'b1;
            exp_ea = base;
            if (HALT) begin
                exp_wr = 1; exp_err = 1; exp_len = 1 + to;
            end else begin
                exp_rd = int'(WC); exp_err = 2 * int'(WC); exp_len = 2 * int'(WC) * (1 + to);
            end
        end else begin
            wlen    = 1 + ((d + 1 > 2) ? d + 1 : 2);
            rlen    = d + 2;
            for (int i = 0; i < int'(WC); i++) begin
                if (!(HALT && exp_err != 0)) begin
                    exp_rd++;
                    if (mask[i]) begin
                        if (exp_err == 0) exp_ea = base + 32'(4 * i);
                        exp_err++;
                    end
                end
            end
            exp_len = int'(WC) * wlen + exp_rd * rlen;
        end
        exp_pass = (exp_err == 0) && !exp_to;

        chk("busy_low",   32'(busy[k]), 32'h0);
        chk("pass",       32'(pass_o[k]), 32'(exp_pass));
        chk("timeout",    32'(tmo[k]), 32'(exp_to));
        chk("err_count",  32'(err_cnt[k]), 32'(exp_err));
        chk("err_addr",   err_addr[k], exp_ea);
        chk("run_length", 32'(busy_cyc[k] - s_busy), 32'(exp_len));
        chk("n_writes",   32'(wr_n[k] - s_wr), 32'(exp_wr));
        chk("n_reads",    32'(rd_n[k] - s_rd), 32'(exp_rd));
        chk("strobe_bad", 32'(strobe_bad[k] - s_bad), 32'h0);
        for (int i = 0; i < exp_wr; i++) begin
            chk($sformatf("wr_addr%0d", i), wr_addr_log[k][8'(s_wr + i)], base + 32'(4 * i));
            chk($sformatf("wr_data%0d", i), wr_data_log[k][8'(s_wr + i)], (base + 32'(4 * i)) ^ PAT);
        end
        for (int i = 0; i < exp_rd; i++) begin
            chk($sformatf("rd_addr%0d", i), rd_log[k][8'(s_rd + i)], base + 32'(4 * i));
        end
    endtask

    initial begin
        int s_wr;
        rst_n = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(0, 0, 1'b0, 4'b0000, 1'b0);   // ideal memory, 20-cycle run
        do_run(0, 0, 1'b0, 4'b0100, 1'b0);   // bit flip at 0x8
        do_run(0, 10, 1'b0, 4'b0000, 1'b0);  // 10-cycle miss on every access
        do_run(0, 1, 1'b0, 4'b0110, 1'b0);   // mismatches at 0x4 and 0x8
        do_run(1, 0, 1'b1, 4'b0000, 1'b0);   // valid never asserted
        do_run(1, 2, 1'b0, 4'b0000, 1'b1);   // wrapping addresses, start ignored while busy

        for (int r = 0; r < 6; r++) begin
            do_run(0, int'($urandom_range(0, 4)), 1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the read phase.
        @(negedge clk);
        delay[0] = 10; valid_off[0] = 1'b0; corrupt[0] = 4'h0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 0; c < 500 && !rd_phase[0]; c++) @(negedge clk);
        chk("reached_read_phase", 32'(rd_phase[0]), 32'h1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        s_wr = wr_n[0];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_write_after_reset", 32'(wr_n[0] - s_wr), 32'h0);
        chk("idle_after_reset", 32'(busy[0]), 32'h0);
        do_run(0, 0, 1'b0, 4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_test_sequencer.md
MEM_TEST_SEQUENCER -- requirements
Module: mem_test_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: first byte address tested; must be word-aligned.
REQ-002 SHALL have parameter WORD_COUNT, default 1024: number of 32-bit words tested; range 1..65536.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for data_out_valid per access; range 1..65535.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have clk  input  1  rising-edge clock.
REQ-006 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have start  input  1  one-cycle pulse that starts a test run; ignored unless state is IDLE or DONE.
REQ-008 SHALL have address  output  32  cache byte address.
REQ-009 SHALL have data_in  output  32  cache write data.
REQ-010 SHALL have write_enable  output  4  cache byte-lane write strobes.
REQ-011 SHALL have data_out  input  32  cache read data.
REQ-012 SHALL have data_out_valid  input  1  cache hit/ready indication for the current address.
REQ-013 SHALL have busy  output  1  high while a run is in progress.
REQ-014 SHALL have done  output  1  high from run end until the next start.
REQ-015 SHALL have pass  output  1  high while done and no mismatch or timeout occurred.
REQ-016 SHALL have timeout  output  1  sticky flag; set when any access exceeds TIMEOUT_CYCLES.
REQ-017 SHALL have err_count  output  16  mismatch count; saturates at 16'hFFFF.
REQ-018 SHALL have err_addr  output  32  address of the first mismatch; 0 when there is none.

Function
REQ-019 SHALL define pattern(a) = a XOR 32'hA5A5_5A5A.
REQ-020 SHALL step the word index i through 0..WORD_COUNT-1, with address = BASE_ADDR + 4*i (32-bit wrap-around).
REQ-021 SHALL implement FSM states IDLE, WR_STROBE, WR_WAIT, RD_SETTLE, RD_WAIT and DONE.
REQ-022 SHALL, on start in IDLE or DONE, clear i, err_count, err_addr, timeout and done, set busy, drive address=BASE_ADDR and data_in=pattern(BASE_ADDR), and enter WR_STROBE.
REQ-023 SHALL drive write_enable=4'b1111 for exactly one cycle in WR_STROBE, then drive write_enable=0 and enter WR_WAIT.
REQ-024 SHALL, in WR_WAIT, ignore data_out_valid on the first cycle and advance on the first later cycle in which data_out_valid=1.
REQ-025 SHALL, when advancing from WR_WAIT with i < WORD_COUNT-1, increment i, update address and data_in in the same cycle, and return to WR_STROBE.
REQ-026 SHALL, after the last write, reset i to 0, drive address=BASE_ADDR and enter RD_SETTLE; write_enable SHALL stay 0 throughout the read phase.
REQ-027 SHALL spend exactly one cycle in RD_SETTLE, ignoring stale data_out_valid, then enter RD_WAIT.
REQ-028 SHALL, in RD_WAIT, sample data_out on the cycle data_out_valid=1 and compare it with pattern(address).
REQ-029 SHALL, on a mismatch, increment err_count (saturating) and load err_addr only if err_count was 0.
REQ-030 SHALL, after a read with i < WORD_COUNT-1, increment i, update address and enter RD_SETTLE; after the last read it SHALL enter DONE.
REQ-031 SHALL, in DONE, have busy=0 and done=1, with pass = (err_count==0 && !timeout).
REQ-032 SHALL count the cycles spent in WR_WAIT or RD_WAIT; on reaching TIMEOUT_CYCLES it SHALL set timeout and count the access as failed, then advance as if data_out_valid had been asserted.
REQ-033 SHALL ignore start while busy=1.
REQ-034 SHALL have a latency, with data_out_valid always high, of 3 cycles per write and 2 cycles per read.

Reset
REQ-035 SHALL, while rst_n=0, asynchronously force state=IDLE, address=0, data_in=0, write_enable=0, busy=0, done=0, pass=0, timeout=0, err_count=0 and err_addr=0.
REQ-036 SHALL abandon any run on reset mid-operation, with no further writes issued after release; release SHALL require a new start.

Configuration
REQ-037 SHALL, with MEM_TEST_SEQUENCER_HALT_ON_ERROR_EN defined, enter DONE immediately after the first mismatch or timeout, with err_count=1 and the remaining words untested.
REQ-038 SHALL, without MEM_TEST_SEQUENCER_HALT_ON_ERROR_EN, test all WORD_COUNT words regardless of errors.

Structure
REQ-039 SHALL take the state encoding (enum), the PATTERN_XOR constant (32'hA5A5_5A5A) and the pattern function from shared package mem_test_pkg.
REQ-040 SHALL implement the per-access timeout counter (load, count, expire) as sub-module mem_test_watchdog.

Verification
REQ-041 SHALL verify: WORD_COUNT=4, ideal memory with valid always 1, start -> four writes at 0x0,0x4,0x8,0xC with data 0xA5A55A5A, 0xA5A55A5E, 0xA5A55A52, 0xA5A55A56, then four reads, done=1, pass=1, run length 20 cycles.
REQ-042 SHALL verify: memory model that flips bit 0 at address 0x8 -> done=1, pass=0, err_count=1, err_addr=0x8.
REQ-043 SHALL verify: valid held low for 10 cycles per access (a simulated cache miss) -> still pass=1, with each write strobe one cycle wide and no strobe issued while waiting.
REQ-044 SHALL verify: valid never asserted, TIMEOUT_CYCLES=5 -> timeout=1, pass=0, done reached without hang.
REQ-045 SHALL verify: rst_n pulsed low during the read phase -> all outputs at reset values immediately; a subsequent start completes with pass=1.
REQ-046 SHALL verify: HALT_ON_ERROR_EN defined with mismatches at 0x4 and 0x8 -> err_count=1, err_addr=0x4, and no read issued to 0x8.
